// File: rtl/single_port_memory_arbiter_pkg.sv
// rtl/single_port_memory_arbiter_pkg.sv - shared encodings for the single-port memory arbiter
//
// Purpose: arbiter state and read-owner encodings, plus the latency counter type
// shared by the top level and the read latency tracker.
// Ports: none (package).
package single_port_memory_arbiter_pkg;

  // Arbiter FSM states
  localparam logic ARB_IDLE = 1'b0;
  localparam logic ARB_WAIT = 1'b1;

  // Owner of the outstanding read
  localparam logic ARB_OWNER_IF = 1'b0;
  localparam logic ARB_OWNER_D  = 1'b1;

  // READ_LATENCY is limited to 1..7, so the down-counter needs 3 bits
  localparam int LAT_CNT_W = 3;
  typedef logic [LAT_CNT_W-1:0] lat_cnt_t;

endpackage

// File: rtl/single_port_memory_arbiter_mem_read_latency_tracker.sv
// rtl/single_port_memory_arbiter_mem_read_latency_tracker.sv - read latency counter and rvalid pulse
//
// Purpose: counts READ_LATENCY cycles after a read is issued and pulses the
// owner's rvalid in the cycle memory data is valid.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   load         a read is issued this cycle (loads counter and owner)
//   load_owner   owner of the read being issued (ARB_OWNER_IF / ARB_OWNER_D)
//   active       arbiter is in WAIT
//   done         read data valid this cycle; arbiter returns to IDLE
//   if_rvalid    done, owned by instruction fetch
//   d_rvalid     done, owned by the data port
module mem_read_latency_tracker
  import single_port_memory_arbiter_pkg::*;
#(
  parameter int READ_LATENCY = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic load_owner,
  input  logic active,
  output logic done,
  output logic if_rvalid,
  output logic d_rvalid
);

  lat_cnt_t cnt;
  logic     owner;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      owner <= ARB_OWNER_IF;
    end else if (load) begin
      // The issue cycle itself is cycle 0, so WAIT starts at READ_LATENCY-1
      cnt   <= lat_cnt_t'(READ_LATENCY - 1);
      owner <= load_owner;
    end else if (active && cnt != '0) begin
      cnt <= cnt - lat_cnt_t'(1);
    end
  end

  assign done      = active && (cnt == '0);
  assign if_rvalid = done && (owner == ARB_OWNER_IF);
  assign d_rvalid  = done && (owner == ARB_OWNER_D);

endmodule

// File: rtl/single_port_memory_arbiter.sv
// rtl/single_port_memory_arbiter.sv - shares one single-port memory between fetch and data
//
// Purpose: arbitrates fetch (IF) and data (D) requests onto one memory port,
// alternating on ties, with one read outstanding at a time.
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   if_req/if_addr -> if_ack         fetch read request and acceptance
//   if_rvalid/if_rdata               fetched word
//   d_req/d_we/d_addr/d_wdata -> d_ack   data load/store request and acceptance
//   d_rvalid/d_rdata                 load data
//   mem_addr/mem_wdata/mem_we/mem_re memory command
//   mem_rdata                        memory read data, READ_LATENCY cycles after mem_re
module single_port_memory_arbiter
  import single_port_memory_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_ack,
  output logic                  if_rvalid,
  output logic [DATA_WIDTH-1:0] if_rdata,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic                  d_ack,
  output logic                  d_rvalid,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_we,
  output logic                  mem_re,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  logic state;
  logic tie_d_first;
  logic grant_if;
  logic grant_d;
  logic issue_read;
  logic rd_done;
  logic if_rv;
  logic d_rv;

  // Grants are gated by rst_n so acks and memory strobes stay low while
  // reset is held, even with requests pending.
  always_comb begin
    grant_if = 1'b0;
    grant_d  = 1'b0;
    if (rst_n && state == ARB_IDLE) begin
      if (if_req && d_req) begin
        grant_d  = tie_d_first;
        grant_if = !tie_d_first;
      end else begin
        grant_d  = d_req;
        grant_if = if_req;
      end
    end
  end

  assign issue_read = grant_if || (grant_d && !d_we);

  assign if_ack    = grant_if;
  assign d_ack     = grant_d;
  assign mem_re    = issue_read;
  assign mem_we    = grant_d && d_we;
  assign mem_addr  = grant_d ? d_addr : (grant_if ? if_addr : '0);
  assign mem_wdata = grant_d ? d_wdata : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ARB_IDLE;
    end else if (state == ARB_IDLE) begin
      // Stores complete on issue, so only reads leave IDLE
      if (issue_read) state <= ARB_WAIT;
    end else if (rd_done) begin
      state <= ARB_IDLE;
    end
  end

  // Fairness bit moves only when both sides competed for the grant
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tie_d_first <= 1'b1;
    end else if ((grant_if || grant_d) && if_req && d_req) begin
      tie_d_first <= !tie_d_first;
    end
  end

  mem_read_latency_tracker #(
    .READ_LATENCY(READ_LATENCY)
  ) u_tracker (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (issue_read),
    .load_owner(grant_d ? ARB_OWNER_D : ARB_OWNER_IF),
    .active    (state == ARB_WAIT),
    .done      (rd_done),
    .if_rvalid (if_rv),
    .d_rvalid  (d_rv)
  );

  assign if_rvalid = if_rv;
  assign d_rvalid  = d_rv;
  assign if_rdata  = if_rv ? mem_rdata : '0;
  assign d_rdata   = d_rv ? mem_rdata : '0;

endmodule

// File: tb/tb_single_port_memory_arbiter.sv
// tb/tb_single_port_memory_arbiter.sv - bench for the single-port memory arbiter
module tb_single_port_memory_arbiter;

  localparam int LAT0 = 1;
  localparam int LAT1 = 3;

  logic        clk;
  logic        rst_n     [2];
  logic        if_req    [2];
  logic [31:0] if_addr   [2];
  logic        if_ack    [2];
  logic        if_rvalid [2];
  logic [31:0] if_rdata  [2];
  logic        d_req     [2];
  logic        d_we      [2];
  logic [31:0] d_addr    [2];
  logic [31:0] d_wdata   [2];
  logic        d_ack     [2];
  logic        d_rvalid  [2];
  logic [31:0] d_rdata   [2];
  logic [31:0] mem_addr  [2];
  logic [31:0] mem_wdata [2];
  logic        mem_we    [2];
  logic        mem_re    [2];
  logic [31:0] mem_rdata [2];

  int total = 0;
  int bad   = 0;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    single_port_memory_arbiter #(
      .ADDR_WIDTH  (32),
      .DATA_WIDTH  (32),
      .READ_LATENCY(g == 0 ? LAT0 : LAT1)
    ) u_dut (
      .clk      (clk),
      .rst_n    (rst_n[g]),
      .if_req   (if_req[g]),
      .if_addr  (if_addr[g]),
      .if_ack   (if_ack[g]),
      .if_rvalid(if_rvalid[g]),
      .if_rdata (if_rdata[g]),
      .d_req    (d_req[g]),
      .d_we     (d_we[g]),
      .d_addr   (d_addr[g]),
      .d_wdata  (d_wdata[g]),
      .d_ack    (d_ack[g]),
      .d_rvalid (d_rvalid[g]),
      .d_rdata  (d_rdata[g]),
      .mem_addr (mem_addr[g]),
      .mem_wdata(mem_wdata[g]),
      .mem_we   (mem_we[g]),
      .mem_re   (mem_re[g]),
      .mem_rdata(mem_rdata[g])
    );
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    if (a == 32'h40) return 32'hDEADBEEF;
    return (a ^ 32'hC3A5_0000) + 32'h11;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h", name, act, exp);
    end
  endtask

  // Memory: returns mem_fn(addr) exactly READ_LATENCY cycles after mem_re,
  // and junk on every other cycle.
  logic        cap_v  [2];
  logic [31:0] cap_a  [2];
  logic        pipe_v [2][8];
  logic [31:0] pipe_a [2][8];

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      cap_v[k] <= mem_re[k];
      cap_a[k] <= mem_addr[k];
    end
  end

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      pipe_v[k][0] <= cap_v[k];
      pipe_a[k][0] <= cap_a[k];
      for (int i = 1; i < 8; i++) begin
        pipe_v[k][i] <= pipe_v[k][i-1];
        pipe_a[k][i] <= pipe_a[k][i-1];
      end
      if (k == 0 ? cap_v[k] : pipe_v[k][LAT1-2])
        mem_rdata[k] <= mem_fn(k == 0 ? cap_a[k] : pipe_a[k][LAT1-2]);
      else
        mem_rdata[k] <= $urandom;
    end
  end

  // Reference model: one pending read with a remaining-cycle count, a
  // D-first tie flag, and the address of the outstanding read.
  bit          m_busy   [2];
  int          m_remain [2];
  bit          m_own_d  [2];
  logic [31:0] m_raddr  [2];
  bit          m_tie_d  [2];
  logic        if_ack_seen [2];
  logic        d_ack_seen  [2];

  task automatic model_check(input int k);
    logic        e_ia, e_da, e_iv, e_dv, e_we, e_re, gi, gd;
    logic [31:0] e_addr, e_wd, e_ird, e_drd;
    int          lat;
    lat = (k == 0) ? LAT0 : LAT1;
    e_ia = 0; e_da = 0; e_iv = 0; e_dv = 0; e_we = 0; e_re = 0;
    e_addr = 0; e_wd = 0; e_ird = 0; e_drd = 0;
    if (!rst_n[k]) begin
      m_busy[k]  = 0;
      m_tie_d[k] = 1;
    end else if (m_busy[k]) begin
      m_remain[k]--;
      if (m_remain[k] == 0) begin
        m_busy[k] = 0;
        if (m_own_d[k]) begin e_dv = 1; e_drd = mem_fn(m_raddr[k]); end
        else begin e_iv = 1; e_ird = mem_fn(m_raddr[k]); end
      end
    end else begin
      gi = if_req[k];
      gd = d_req[k];
      if (gi && gd) begin
        if (m_tie_d[k]) gi = 0; else gd = 0;
        m_tie_d[k] = !m_tie_d[k];
      end
      if (gd) begin
        e_da = 1; e_addr = d_addr[k]; e_wd = d_wdata[k];
        e_we = d_we[k]; e_re = !d_we[k];
        if (!d_we[k]) begin
          m_busy[k] = 1; m_remain[k] = lat; m_own_d[k] = 1; m_raddr[k] = d_addr[k];
        end
      end else if (gi) begin
        e_ia = 1; e_addr = if_addr[k]; e_re = 1;
        m_busy[k] = 1; m_remain[k] = lat; m_own_d[k] = 0; m_raddr[k] = if_addr[k];
      end
    end
    check($sformatf("dut%0d if_ack", k),    if_ack[k],    e_ia);
    check($sformatf("dut%0d d_ack", k),     d_ack[k],     e_da);
    check($sformatf("dut%0d if_rvalid", k), if_rvalid[k], e_iv);
    check($sformatf("dut%0d d_rvalid", k),  d_rvalid[k],  e_dv);
    check($sformatf("dut%0d if_rdata", k),  if_rdata[k],  e_ird);
    check($sformatf("dut%0d d_rdata", k),   d_rdata[k],   e_drd);
    check($sformatf("dut%0d mem_re", k),    mem_re[k],    e_re);
    check($sformatf("dut%0d mem_we", k),    mem_we[k],    e_we);
    check($sformatf("dut%0d mem_addr", k),  mem_addr[k],  e_addr);
    check($sformatf("dut%0d mem_wdata", k), mem_wdata[k], e_wd);
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      model_check(k);
      if_ack_seen[k] <= if_ack[k];
      d_ack_seen[k]  <= d_ack[k];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_random(input int k);
    if (!rst_n[k]) rst_n[k] = 1'b1;
    else if ($urandom_range(0, 299) == 0) rst_n[k] = 1'b0;
    if (if_req[k] && !if_ack_seen[k]) begin
      if ($urandom_range(0, 19) == 0) if_req[k] = 1'b0;
    end else begin
      if_req[k]  = ($urandom_range(0, 9) < 5);
      if_addr[k] = $urandom & 32'hFFFF_FFFC;
    end
    if (d_req[k] && !d_ack_seen[k]) begin
      if ($urandom_range(0, 19) == 0) d_req[k] = 1'b0;
    end else begin
      d_req[k]   = ($urandom_range(0, 9) < 5);
      d_we[k]    = ($urandom_range(0, 2) == 0);
      d_addr[k]  = $urandom & 32'hFFFF_FFFC;
      d_wdata[k] = $urandom;
    end
  endtask

  task automatic idle_all();
    for (int k = 0; k < 2; k++) begin
      if_req[k] = 0; d_req[k] = 0; d_we[k] = 0;
    end
  endtask

  int n;

  initial begin
    for (int k = 0; k < 2; k++) begin
      rst_n[k] = 0; if_addr[k] = 0; d_addr[k] = 0; d_wdata[k] = 0;
    end
    idle_all();
    // Reset state with requests pending: nothing may be acked
    if_req[0] = 1; d_req[0] = 1;
    @(negedge clk);
    check("rst if_ack", if_ack[0], 0);
    check("rst d_ack", d_ack[0], 0);
    check("rst mem_re", mem_re[0], 0);
    tick();
    idle_all();
    rst_n[0] = 1; rst_n[1] = 1;

    // IF-only read of 0x40, latency 1
    tick();
    if_req[0] = 1; if_addr[0] = 32'h40;
    @(negedge clk);
    check("t1 if_ack", if_ack[0], 1);
    check("t1 mem_re", mem_re[0], 1);
    check("t1 mem_addr", mem_addr[0], 32'h40);
    tick();
    if_req[0] = 0;
    @(negedge clk);
    check("t1 if_rvalid", if_rvalid[0], 1);
    check("t1 if_rdata", if_rdata[0], 32'hDEADBEEF);
    tick();

    // Both requesting continuously: D, IF, D, IF
    if_req[0] = 1; if_addr[0] = 32'h200;
    d_req[0] = 1; d_we[0] = 0; d_addr[0] = 32'h100;
    n = 0;
    for (int c = 0; c < 20 && n < 4; c++) begin
      @(negedge clk);
      if (d_ack[0] || if_ack[0]) begin
        check($sformatf("t2 tie%0d d_ack", n), d_ack[0], (n % 2 == 0));
        n++;
      end
      tick();
    end
    check("t2 grant count", n, 4);
    idle_all();
    repeat (3) tick();

    // Three back-to-back stores
    for (int i = 0; i < 3; i++) begin
      d_req[0] = 1; d_we[0] = 1; d_addr[0] = 32'h10 + 4 * i; d_wdata[0] = i + 1;
      @(negedge clk);
      check($sformatf("t3 st%0d d_ack", i), d_ack[0], 1);
      check($sformatf("t3 st%0d mem_we", i), mem_we[0], 1);
      check($sformatf("t3 st%0d mem_addr", i), mem_addr[0], 32'h10 + 4 * i);
      check($sformatf("t3 st%0d mem_wdata", i), mem_wdata[0], i + 1);
      check($sformatf("t3 st%0d d_rvalid", i), d_rvalid[0], 0);
      tick();
    end
    idle_all();
    @(negedge clk);
    check("t3 after d_rvalid", d_rvalid[0], 0);
    check("t3 after mem_we", mem_we[0], 0);
    tick();

    // Latency 3: load then fetch; fetch acked only after d_rvalid
    d_req[1] = 1; d_we[1] = 0; d_addr[1] = 32'h300;
    @(negedge clk);
    check("t4 d_ack", d_ack[1], 1);
    check("t4 mem_re", mem_re[1], 1);
    tick();
    d_req[1] = 0; if_req[1] = 1; if_addr[1] = 32'h80;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      check($sformatf("t4 c%0d if_ack", c), if_ack[1], 0);
      check($sformatf("t4 c%0d d_rvalid", c), d_rvalid[1], c == 3);
      tick();
    end
    @(negedge clk);
    check("t4 if_ack after", if_ack[1], 1);
    tick();
    if_req[1] = 0;
    repeat (4) tick();

    // Reset during WAIT on the latency-3 unit, tie bit previously moved to IF
    if_req[1] = 1; if_addr[1] = 32'h84;
    d_req[1] = 1; d_we[1] = 0; d_addr[1] = 32'h310;
    @(negedge clk);
    check("t5 first tie d_ack", d_ack[1], 1);
    tick();
    d_req[1] = 0;
    tick();
    rst_n[1] = 0;
    @(negedge clk);
    check("t5 rst if_ack", if_ack[1], 0);
    check("t5 rst mem_re", mem_re[1], 0);
    check("t5 rst d_rvalid", d_rvalid[1], 0);
    check("t5 rst mem_addr", mem_addr[1], 0);
    tick();
    rst_n[1] = 1;
    d_req[1] = 1; d_addr[1] = 32'h318;
    @(negedge clk);
    check("t5 tie after rst d_ack", d_ack[1], 1);
    check("t5 tie after rst if_ack", if_ack[1], 0);
    tick();
    idle_all();
    repeat (5) tick();

    // Fetch withdrawn while stalled behind a load
    d_req[0] = 1; d_we[0] = 0; d_addr[0] = 32'h120;
    @(negedge clk);
    check("t6 d_ack", d_ack[0], 1);
    tick();
    d_req[0] = 0; if_req[0] = 1; if_addr[0] = 32'h88;
    @(negedge clk);
    check("t6 stall if_ack", if_ack[0], 0);
    check("t6 d_rvalid", d_rvalid[0], 1);
    tick();
    if_req[0] = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("t6 c%0d mem_re", c), mem_re[0], 0);
      check($sformatf("t6 c%0d if_ack", c), if_ack[0], 0);
      tick();
    end

    // Random traffic on both units against the model
    for (int cyc = 0; cyc < 4000; cyc++) begin
      for (int k = 0; k < 2; k++) drive_random(k);
      tick();
    end
    idle_all();
    rst_n[0] = 1; rst_n[1] = 1;
    repeat (10) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
